// File: rtl/reg_native_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_native_arb_pkg
// Shared types and helpers for the native register-interface arbiter.
//   arb_state_e : arbiter FSM states (IDLE, WAIT, REJECT, DRAIN)
//   tmo_cnt_w() : width of the WAIT-cycle counter for a given TIMEOUT
// -----------------------------------------------------------------------------
package reg_native_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_REJECT = 2'd2,
      ST_DRAIN  = 2'd3
   } arb_state_e;

   // The counter only has to reach TIMEOUT-1; never narrower than one bit so
   // TIMEOUT = 0 (disabled) and TIMEOUT = 1 still elaborate.
   function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
      int unsigned w;
      w = (timeout > 1) ? $clog2(timeout) : 1;
      return w;
   endfunction

endpackage

// File: rtl/reg_rr_arbiter.sv
// -----------------------------------------------------------------------------
// reg_rr_arbiter
// Combinational round-robin picker. The search starts just above ptr and wraps,
// so the last winner gets lowest priority.
//   req     in  N   request vector
//   ptr     in  IW  index of the previous winner
//   gnt     out N   one-hot grant (zero when nothing requests)
//   gnt_idx out IW  index of the granted requester
//   any_req out 1   at least one request is set
// -----------------------------------------------------------------------------
module reg_rr_arbiter #(
   parameter  int unsigned N  = 2,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any_req
);

   localparam logic [IW:0] N_L = (IW+1)'(N);

   logic [IW:0]  start;
   logic [IW:0]  off;
   logic [IW:0]  pos;
   logic [N-1:0] rot;

   assign any_req = |req;

   always_comb begin
      start = {1'b0, ptr} + 1'b1;
      if (start == N_L) begin
         start = '0;
      end
      // Rotate so bit 0 of rot is the highest-priority requester.
      rot = N'({req, req} >> start);
      off = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (rot[i]) begin
            off = (IW+1)'(i);
         end
      end
      pos = start + off;
      if (pos >= N_L) begin
         pos = pos - N_L;
      end
      gnt_idx = pos[IW-1:0];
      gnt     = any_req ? (N'(1) << gnt_idx) : '0;
   end

endmodule

// File: rtl/reg_native_if_arbiter.sv
// -----------------------------------------------------------------------------
// reg_native_if_arbiter
// Shares one downstream native register interface among N_REQ upstream
// requesters. Round-robin, one transaction in flight, local reject of
// malformed requests (wr_en == rd_en) and a WAIT watchdog (TIMEOUT = 0 off).
//   clk, rst_n           clock, asynchronous active-low reset
//   s_req_vld/s_wr_en/s_rd_en [N_REQ]  per-requester request and direction
//   s_addr, s_wr_data    flattened payloads, requester i at slice i
//   s_ack_vld [N_REQ]    one-cycle ack to the granted requester
//   s_rd_data, s_err     shared, meaningful only with an s_ack_vld bit
//   m_req_vld            one-cycle downstream request pulse
//   m_wr_en/m_rd_en/m_addr/m_wr_data  downstream payload, held until next grant
//   m_ack_vld/m_rd_data/m_err         downstream response
//   busy                 FSM is not IDLE
//   gnt_id               current or last grant index
// Handshake: an upstream request is a level held with its payload through the
// ack cycle; the ack cycle always returns to IDLE, so a requester still
// holding s_req_vld afterwards is a new request from the following cycle.
// -----------------------------------------------------------------------------
module reg_native_if_arbiter
   import reg_native_arb_pkg::*;
#(
   parameter  int unsigned N_REQ      = 2,
   parameter  int unsigned ADDR_WIDTH = 48,
   parameter  int unsigned DATA_WIDTH = 32,
   parameter  int unsigned TIMEOUT    = 1024,
   localparam int unsigned ID_W       = $clog2(N_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            s_req_vld,
   input  logic [N_REQ-1:0]            s_wr_en,
   input  logic [N_REQ-1:0]            s_rd_en,
   input  logic [N_REQ*ADDR_WIDTH-1:0] s_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0] s_wr_data,
   output logic [N_REQ-1:0]            s_ack_vld,
   output logic [DATA_WIDTH-1:0]       s_rd_data,
   output logic                        s_err,
   output logic                        m_req_vld,
   output logic                        m_wr_en,
   output logic                        m_rd_en,
   output logic [ADDR_WIDTH-1:0]       m_addr,
   output logic [DATA_WIDTH-1:0]       m_wr_data,
   input  logic                        m_ack_vld,
   input  logic [DATA_WIDTH-1:0]       m_rd_data,
   input  logic                        m_err,
   output logic                        busy,
   output logic [ID_W-1:0]             gnt_id
);

   localparam int unsigned     CNT_W    = tmo_cnt_w(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   arb_state_e             state_q, state_d;
   logic [ID_W-1:0]        gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]        ptr_q, ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   m_req_vld_q, m_req_vld_d;
   logic                   m_wr_en_q, m_wr_en_d;
   logic                   m_rd_en_q, m_rd_en_d;
   logic [ADDR_WIDTH-1:0]  m_addr_q, m_addr_d;
   logic [DATA_WIDTH-1:0]  m_wr_data_q, m_wr_data_d;

   logic [N_REQ-1:0]       arb_gnt;
   logic [ID_W-1:0]        arb_idx;
   logic                   arb_any;

   logic                   sel_wr, sel_rd;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_wdata;
   logic [N_REQ-1:0]       ack_vec;

   reg_rr_arbiter #(.N(N_REQ)) u_rr (
      .req     (s_req_vld),
      .ptr     (ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any_req (arb_any)
   );

   // AND-OR mux of the winner's payload using the one-hot grant.
   always_comb begin
      sel_wr    = 1'b0;
      sel_rd    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_gnt[i]) begin
            sel_wr    = s_wr_en[i];
            sel_rd    = s_rd_en[i];
            sel_addr  = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = s_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign ack_vec = N_REQ'(1) << gnt_id_q;

   always_comb begin
      state_d     = state_q;
      gnt_id_d    = gnt_id_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      m_req_vld_d = 1'b0;
      m_wr_en_d   = m_wr_en_q;
      m_rd_en_d   = m_rd_en_q;
      m_addr_d    = m_addr_q;
      m_wr_data_d = m_wr_data_q;
      s_ack_vld   = '0;
      s_rd_data   = '0;
      s_err       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               gnt_id_d = arb_idx;
               if (sel_wr ^ sel_rd) begin
                  m_req_vld_d = 1'b1;
                  m_wr_en_d   = sel_wr;
                  m_rd_en_d   = sel_rd;
                  m_addr_d    = sel_addr;
                  m_wr_data_d = sel_wdata;
                  cnt_d       = '0;
                  state_d     = ST_WAIT;
               end else begin
                  state_d = ST_REJECT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // A real ack in the timeout cycle takes precedence.
            if (m_ack_vld) begin
               s_ack_vld = ack_vec;
               s_rd_data = m_rd_data;
               s_err     = m_err;
               ptr_d     = gnt_id_q;
               state_d   = ST_IDLE;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               s_ack_vld = ack_vec;
               s_err     = 1'b1;
               ptr_d     = gnt_id_q;
               state_d   = ST_DRAIN;
            end
         end
         ST_REJECT: begin
            s_ack_vld = ack_vec;
            s_err     = 1'b1;
            ptr_d     = gnt_id_q;
            state_d   = ST_IDLE;
         end
         ST_DRAIN: begin
            // Swallow the late downstream ack; the requester was already answered.
            if (m_ack_vld) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         gnt_id_q    <= '0;
         ptr_q       <= ID_W'(N_REQ - 1);
         cnt_q       <= '0;
         m_req_vld_q <= 1'b0;
         m_wr_en_q   <= 1'b0;
         m_rd_en_q   <= 1'b0;
         m_addr_q    <= '0;
         m_wr_data_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_id_q    <= gnt_id_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         m_req_vld_q <= m_req_vld_d;
         m_wr_en_q   <= m_wr_en_d;
         m_rd_en_q   <= m_rd_en_d;
         m_addr_q    <= m_addr_d;
         m_wr_data_q <= m_wr_data_d;
      end
   end

   assign m_req_vld = m_req_vld_q;
   assign m_wr_en   = m_wr_en_q;
   assign m_rd_en   = m_rd_en_q;
   assign m_addr    = m_addr_q;
   assign m_wr_data = m_wr_data_q;
   assign busy      = (state_q != ST_IDLE);
   assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_reg_native_if_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_native_if_arbiter
// Transaction-level model: each requester owns a queue of items (payload plus
// the downstream latency/response the bench slave will give). Expected grant
// order, ack cycle, error and read data are derived from the arbitration
// rules as absolute cycle numbers.
// -----------------------------------------------------------------------------
module tb_reg_native_if_arbiter;

   localparam int N  = 2;
   localparam int AW = 48;
   localparam int DW = 32;
   localparam int TO = 8;

   // ---------------- clock / reset / DUT ----------------
   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    s_req_vld, s_wr_en, s_rd_en;
   logic [N*AW-1:0] s_addr;
   logic [N*DW-1:0] s_wr_data;
   logic [N-1:0]    s_ack_vld;
   logic [DW-1:0]   s_rd_data;
   logic            s_err;
   logic            m_req_vld, m_wr_en, m_rd_en;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wr_data;
   logic            m_ack_vld;
   logic [DW-1:0]   m_rd_data;
   logic            m_err;
   logic            busy;
   logic [0:0]      gnt_id;

   always #5 clk = ~clk;

   reg_native_if_arbiter #(
      .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_req_vld(s_req_vld), .s_wr_en(s_wr_en), .s_rd_en(s_rd_en),
      .s_addr(s_addr), .s_wr_data(s_wr_data),
      .s_ack_vld(s_ack_vld), .s_rd_data(s_rd_data), .s_err(s_err),
      .m_req_vld(m_req_vld), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
      .m_addr(m_addr), .m_wr_data(m_wr_data),
      .m_ack_vld(m_ack_vld), .m_rd_data(m_rd_data), .m_err(m_err),
      .busy(busy), .gnt_id(gnt_id)
   );

   // ---------------- items and model state ----------------
   typedef struct {
      logic          wr;
      logic          rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            lat;    // slave ack comes lat cycles after the m_req_vld cycle
      logic          merr;
      logic [DW-1:0] rdata;
      int            gap;    // idle cycles before this requester's next item
   } item_t;

   item_t rq[N][$];
   int    gap[N];
   int    obs_ids[$];

   int    total = 0;
   int    bad   = 0;

   int    last_m, gid_m, win;
   bit    active, ack_pend, rej, tmo;
   int    grant_c, resp_c, ack_c, free_c;
   item_t cur;

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         int j = (last + k) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   function automatic item_t mk(input logic wr, input logic rd, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input int lat, input logic merr,
                                input logic [DW-1:0] rdata, input int g);
      item_t it;
      it.wr = wr; it.rd = rd; it.addr = addr; it.wdata = wdata;
      it.lat = lat; it.merr = merr; it.rdata = rdata; it.gap = g;
      return it;
   endfunction

   function automatic item_t rand_item();
      item_t it;
      int k, r;
      k = $urandom_range(0, 9);
      it.wr    = (k == 1) || (k >= 6);
      it.rd    = (k >= 1) && (k <= 5);
      it.addr  = {16'($urandom), $urandom};
      it.wdata = $urandom;
      r = $urandom_range(0, 9);
      if (r <= 5)      it.lat = r;
      else if (r == 6) it.lat = TO - 1;
      else if (r == 7) it.lat = TO;
      else if (r == 8) it.lat = TO + 2;
      else             it.lat = 1;
      it.merr  = ($urandom_range(0, 4) == 0);
      it.rdata = $urandom;
      it.gap   = $urandom_range(0, 2);
      return it;
   endfunction

   task automatic model_reset();
      last_m = N - 1; gid_m = 0; active = 0; ack_pend = 0; rej = 0; tmo = 0;
      for (int i = 0; i < N; i++) gap[i] = 0;
   endtask

   task automatic idle_inputs();
      s_req_vld = '0; s_wr_en = '0; s_rd_en = '0; s_addr = '0; s_wr_data = '0;
      m_ack_vld = 1'b0; m_rd_data = '0; m_err = 1'b0;
   endtask

   // ---------------- driver + model engine (call at a negedge) ----------------
   task automatic run_engine(input int max_cyc);
      int            cyc;
      logic [N-1:0]  req, exp_ack;
      logic [DW-1:0] drv_rd;
      bit            m_ack, exp_mreq;
      cyc = 0;
      free_c = 0;
      while ((rq[0].size() > 0 || rq[1].size() > 0 || active) && cyc < max_cyc) begin
         for (int i = 0; i < N; i++) begin
            req[i] = (rq[i].size() > 0) && (gap[i] == 0);
            if (req[i]) begin
               s_wr_en[i] = rq[i][0].wr;
               s_rd_en[i] = rq[i][0].rd;
               s_addr[i*AW +: AW]    = rq[i][0].addr;
               s_wr_data[i*DW +: DW] = rq[i][0].wdata;
            end else begin
               s_wr_en[i] = 1'($urandom);
               s_rd_en[i] = 1'($urandom);
               s_addr[i*AW +: AW]    = {16'($urandom), $urandom};
               s_wr_data[i*DW +: DW] = $urandom;
            end
         end
         s_req_vld = req;
         m_ack     = active && !rej && (cyc == resp_c);
         drv_rd    = m_ack ? cur.rdata : $urandom;
         m_ack_vld = m_ack;
         m_rd_data = drv_rd;
         m_err     = m_ack ? cur.merr : 1'($urandom);
         #1;
         chk("busy", busy, active);
         chk("gnt_id", gnt_id, gid_m);
         exp_mreq = active && !rej && (cyc == grant_c + 1);
         chk("m_req_vld", m_req_vld, exp_mreq);
         if (active && !rej) begin
            chk("m_addr", m_addr, cur.addr);
            chk("m_wr_en", m_wr_en, cur.wr);
            chk("m_rd_en", m_rd_en, cur.rd);
            chk("m_wr_data", m_wr_data, cur.wdata);
         end
         exp_ack = (ack_pend && cyc == ack_c) ? (N'(1) << win) : '0;
         chk("s_ack_vld", s_ack_vld, exp_ack);
         if (exp_ack != '0) begin
            chk("s_err", s_err, (rej || tmo) ? 1'b1 : cur.merr);
            chk("s_rd_data", s_rd_data, (rej || tmo) ? '0 : drv_rd);
         end
         if (s_ack_vld != '0) obs_ids.push_back(s_ack_vld[1] ? 1 : 0);

         for (int i = 0; i < N; i++) if (gap[i] > 0) gap[i]--;
         if (!active && req != '0) begin
            win      = rr_pick(req, last_m);
            gid_m    = win;
            cur      = rq[win][0];
            active   = 1;
            ack_pend = 1;
            grant_c  = cyc;
            rej      = (cur.wr == cur.rd);
            tmo      = 0;
            if (rej) begin
               ack_c  = cyc + 1;
               free_c = cyc + 2;
            end else begin
               resp_c = cyc + 1 + cur.lat;
               if (cur.lat <= TO - 1) begin
                  ack_c  = resp_c;
                  free_c = resp_c + 1;
               end else begin
                  tmo    = 1;
                  ack_c  = cyc + TO;
                  free_c = resp_c + 1;
               end
            end
         end else begin
            if (ack_pend && cyc == ack_c) begin
               void'(rq[win].pop_front());
               gap[win] = cur.gap;
               last_m   = win;
               ack_pend = 0;
            end
            if (active && cyc == free_c - 1) active = 0;
         end
         @(negedge clk);
         cyc++;
      end
      chk("engine_bound", (cyc < max_cyc) ? 1 : 0, 1);
      idle_inputs();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s_ack"}, s_ack_vld, 0);
      chk({tag, "_s_err"}, s_err, 0);
      chk({tag, "_s_rd"}, s_rd_data, 0);
      chk({tag, "_m_req"}, m_req_vld, 0);
      chk({tag, "_m_wr"}, m_wr_en, 0);
      chk({tag, "_m_rd"}, m_rd_en, 0);
      chk({tag, "_m_addr"}, m_addr, 0);
      chk({tag, "_m_wdata"}, m_wr_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_gnt_id"}, gnt_id, 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (3) @(negedge clk);
      #1 chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // single read: ack three cycles after the grant, data passed through
      obs_ids.delete();
      rq[0].push_back(mk(1'b0, 1'b1, 48'h100, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0));
      run_engine(200);
      chk("single_ack_count", obs_ids.size(), 1);

      // downstream error on a write from requester 1, then pointer advance
      obs_ids.delete();
      rq[1].push_back(mk(1'b1, 1'b0, 48'h2_0000_0040, 32'hCAFEF00D, 2, 1'b1, 32'h1, 0));
      run_engine(200);
      rq[0].push_back(mk(1'b0, 1'b1, 48'h10, 32'h0, 1, 1'b0, 32'h11, 0));
      rq[1].push_back(mk(1'b0, 1'b1, 48'h20, 32'h0, 1, 1'b0, 32'h22, 0));
      run_engine(200);
      chk("err_order_n", obs_ids.size(), 3);
      if (obs_ids.size() == 3) begin
         chk("err_order_1", obs_ids[1], 0);
         chk("err_order_2", obs_ids[2], 1);
      end

      // malformed request from requester 1: local reject
      rq[1].push_back(mk(1'b1, 1'b1, 48'h30, 32'h33, 1, 1'b0, 32'h0, 0));
      run_engine(200);

      // timeout with a late ack, followed by a normal grant
      rq[0].push_back(mk(1'b0, 1'b1, 48'h40, 32'h0, TO + 2, 1'b0, 32'h44, 0));
      rq[1].push_back(mk(1'b1, 1'b0, 48'h50, 32'h55, 1, 1'b0, 32'h0, 0));
      run_engine(300);

      // ack exactly in the timeout cycle wins
      rq[0].push_back(mk(1'b1, 1'b0, 48'h60, 32'h66, TO - 1, 1'b0, 32'h0, 0));
      run_engine(200);

      // randomized traffic
      for (int n = 0; n < 40; n++) rq[$urandom_range(0, 1)].push_back(rand_item());
      run_engine(5000);

      // reset in the middle of WAIT
      s_req_vld = 2'b10; s_rd_en = 2'b10; s_wr_en = 2'b00;
      s_addr[AW +: AW] = 48'h77;
      @(negedge clk);
      #1;
      chk("rst_pre_m_req", m_req_vld, 1);
      chk("rst_pre_busy", busy, 1);
      chk("rst_pre_gnt", gnt_id, 1);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("rst_mid");
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);

      // fairness after reset: both hold requests, order 0,1,0,1
      obs_ids.delete();
      for (int n = 0; n < 2; n++) begin
         rq[0].push_back(mk(1'b0, 1'b1, 48'h100 + 48'(n), 32'h0, 2, 1'b0, $urandom, 0));
         rq[1].push_back(mk(1'b1, 1'b0, 48'h200 + 48'(n), $urandom, 2, 1'b0, 32'h0, 0));
      end
      run_engine(300);
      chk("fair_n", obs_ids.size(), 4);
      if (obs_ids.size() == 4) begin
         chk("fair_0", obs_ids[0], 0);
         chk("fair_1", obs_ids[1], 1);
         chk("fair_2", obs_ids[2], 0);
         chk("fair_3", obs_ids[3], 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
